csr_unit: RTL and testbench

//  Machine-mode CSR file, second generation. Adds mstatus interrupt-enable stacking on trap/mret,

---
 rtl/csr_pkg.sv | 35 +++
 rtl/csr_unit_if.sv | 15 +
 rtl/csr_counter64.sv | 22 ++
 rtl/csr_unit.sv | 164 ++++++++++++++++
 tb/tb_csr_unit.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/csr_pkg.sv
// Shared encodings for the machine-mode CSR file: op codes, CSR addresses,
// mstatus bit positions and mtvec mode values.
package csr_pkg;

  typedef enum logic [2:0] {
    CSR_OP_RW  = 3'b001,
    CSR_OP_RS  = 3'b010,
    CSR_OP_RC  = 3'b011,
    CSR_OP_RWI = 3'b101,
    CSR_OP_RSI = 3'b110,
    CSR_OP_RCI = 3'b111
  } csr_op_e;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  localparam int IRQ_BASE         = 16;

  localparam logic [1:0] MTVEC_MODE_DIRECT   = 2'b00;
  localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

endpackage

// File: rtl/csr_unit_if.sv
// CSR access port between the decoder and the CSR file.
interface csr_unit_if;
  logic [2:0]  opcode;
  logic [11:0] addr;
  logic [31:0] rs1_data;
  logic [31:0] imm_data;
  logic        write_enable;
  logic [31:0] read_data;
  logic        illegal;

  modport master (output opcode, addr, rs1_data, imm_data, write_enable,
                  input  read_data, illegal);
  modport slave  (input  opcode, addr, rs1_data, imm_data, write_enable,
                  output read_data, illegal);
endinterface

// File: rtl/csr_counter64.sv
// 64-bit event counter with independent 32-bit half writes; a write to
// either half replaces that cycle's increment, the other half holds.
module csr_counter64 (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        inc_i,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] cnt_o
);
  logic [63:0] r_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      r_cnt <= '0;
    else if (wr_lo_i) r_cnt <= {r_cnt[63:32], wdata_i};
    else if (wr_hi_i) r_cnt <= {wdata_i, r_cnt[31:0]};
    else if (inc_i)   r_cnt <= r_cnt + 64'd1;
  end

  assign cnt_o = r_cnt;
endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR file: trap/mret stacking, vectored mtvec, mip/mie
// interrupt request, 64-bit mcycle/minstret and illegal-access detection.
module csr_unit
  import csr_pkg::*;
#(
  parameter int          NUM_IRQ     = 16,
  parameter bit          VECTORED_EN = 1'b1,
  parameter logic [31:0] HART_ID     = 32'd0
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  csr_unit_if.slave          bus,
  input  logic               trap_i,
  input  logic               mret_i,
  input  logic [31:0]        pc_i,
  input  logic [31:0]        mcause_i,
  input  logic [31:0]        tval_i,
  input  logic               instr_ret_i,
  input  logic [NUM_IRQ-1:0] irq_i,
  output logic [31:0]        mepc_o,
  output logic [31:0]        trap_pc_o,
  output logic               irq_req_o,
  output logic [31:0]        irq_cause_o
);
  localparam logic [31:0] MIE_MASK   = 32'(((64'd1 << NUM_IRQ) - 64'd1) << IRQ_BASE);
  localparam logic [31:0] MTVEC_MASK = VECTORED_EN ? 32'hFFFF_FFFD : 32'hFFFF_FFFC;

  logic               r_mie_bit, r_mpie_bit;
  logic [31:0]        r_mie, r_mtvec, r_mscratch, r_mepc, r_mcause, r_mtval;
  logic [NUM_IRQ-1:0] r_irq_q;
  logic [63:0]        w_mcycle, w_minstret;
  logic [31:0]        w_mstatus, w_mip, w_pend, w_rdata, w_opnd, w_wdata, w_tvec_base;
  logic               w_known, w_ro, w_illegal, w_op_ok, w_we;

  always_comb begin
    w_mstatus                   = '0;
    w_mstatus[12:11]            = 2'b11;
    w_mstatus[MSTATUS_MIE_BIT]  = r_mie_bit;
    w_mstatus[MSTATUS_MPIE_BIT] = r_mpie_bit;
  end

  assign w_mip = 32'(r_irq_q) << IRQ_BASE;

  always_comb begin
    w_rdata = '0;
    w_known = 1'b1;
    w_ro    = 1'b0;
    case (bus.addr)
      CSR_MSTATUS:   w_rdata = w_mstatus;
      CSR_MIE:       w_rdata = r_mie;
      CSR_MTVEC:     w_rdata = r_mtvec;
      CSR_MSCRATCH:  w_rdata = r_mscratch;
      CSR_MEPC:      w_rdata = r_mepc;
      CSR_MCAUSE:    w_rdata = r_mcause;
      CSR_MTVAL:     w_rdata = r_mtval;
      CSR_MIP:       begin w_rdata = w_mip;   w_ro = 1'b1; end
      CSR_MCYCLE:    w_rdata = w_mcycle[31:0];
      CSR_MCYCLEH:   w_rdata = w_mcycle[63:32];
      CSR_MINSTRET:  w_rdata = w_minstret[31:0];
      CSR_MINSTRETH: w_rdata = w_minstret[63:32];
      CSR_MHARTID:   begin w_rdata = HART_ID; w_ro = 1'b1; end
      default:       w_known = 1'b0;
    endcase
  end

  assign w_illegal     = !w_known || (w_ro && bus.write_enable);
  assign bus.illegal   = w_illegal;
  assign bus.read_data = w_illegal ? 32'd0 : w_rdata;

  // Bit 2 of the op selects the zimm operand for the immediate forms.
  assign w_opnd = bus.opcode[2] ? bus.imm_data : bus.rs1_data;

  always_comb begin
    w_wdata = '0;
    w_op_ok = 1'b1;
    case (bus.opcode)
      CSR_OP_RW, CSR_OP_RWI: w_wdata = w_opnd;
      CSR_OP_RS, CSR_OP_RSI: w_wdata = w_rdata | w_opnd;
      CSR_OP_RC, CSR_OP_RCI: w_wdata = w_rdata & ~w_opnd;
      default:               w_op_ok = 1'b0;
    endcase
  end

  assign w_we = bus.write_enable && w_op_ok && !w_illegal;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mie      <= '0;
      r_mtvec    <= '0;
      r_mscratch <= '0;
      r_irq_q    <= '0;
    end else begin
      r_irq_q <= irq_i;
      if (w_we && bus.addr == CSR_MIE)      r_mie      <= w_wdata & MIE_MASK;
      if (w_we && bus.addr == CSR_MTVEC)    r_mtvec    <= w_wdata & MTVEC_MASK;
      if (w_we && bus.addr == CSR_MSCRATCH) r_mscratch <= w_wdata;
    end
  end

  // Trap owns the trap-state CSRs outright; mret only blocks an mstatus write.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mie_bit  <= 1'b0;
      r_mpie_bit <= 1'b0;
      r_mepc     <= '0;
      r_mcause   <= '0;
      r_mtval    <= '0;
    end else if (trap_i) begin
      r_mepc     <= pc_i & 32'hFFFF_FFFC;
      r_mcause   <= mcause_i;
      r_mtval    <= tval_i;
      r_mpie_bit <= r_mie_bit;
      r_mie_bit  <= 1'b0;
    end else begin
      if (mret_i) begin
        r_mie_bit  <= r_mpie_bit;
        r_mpie_bit <= 1'b1;
      end else if (w_we && bus.addr == CSR_MSTATUS) begin
        r_mie_bit  <= w_wdata[MSTATUS_MIE_BIT];
        r_mpie_bit <= w_wdata[MSTATUS_MPIE_BIT];
      end
      if (w_we && bus.addr == CSR_MEPC)   r_mepc   <= w_wdata & 32'hFFFF_FFFC;
      if (w_we && bus.addr == CSR_MCAUSE) r_mcause <= w_wdata;
      if (w_we && bus.addr == CSR_MTVAL)  r_mtval  <= w_wdata;
    end
  end

  csr_counter64 u_mcycle (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .inc_i   (1'b1),
    .wr_lo_i (w_we && bus.addr == CSR_MCYCLE),
    .wr_hi_i (w_we && bus.addr == CSR_MCYCLEH),
    .wdata_i (w_wdata),
    .cnt_o   (w_mcycle)
  );

  csr_counter64 u_minstret (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .inc_i   (instr_ret_i),
    .wr_lo_i (w_we && bus.addr == CSR_MINSTRET),
    .wr_hi_i (w_we && bus.addr == CSR_MINSTRETH),
    .wdata_i (w_wdata),
    .cnt_o   (w_minstret)
  );

  assign w_tvec_base = {r_mtvec[31:2], 2'b00};
  // Shifting the whole cause drops bit 31, leaving 4*cause[30:0] mod 2^32.
  assign trap_pc_o = (r_mtvec[1:0] == MTVEC_MODE_VECTORED && mcause_i[31])
                   ? w_tvec_base + (mcause_i << 2) : w_tvec_base;
  assign mepc_o    = r_mepc;

  assign w_pend    = w_mip & r_mie;
  assign irq_req_o = r_mie_bit && (|w_pend);

  // Descending scan so the lowest pending line is the last assignment.
  always_comb begin
    irq_cause_o = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (w_pend[IRQ_BASE + i]) irq_cause_o = {1'b1, 31'(IRQ_BASE + i)};
  end

endmodule

// File: tb/tb_csr_unit.sv
// Directed checks of the CSR file: reset, interrupts, trap/mret, vectoring,
// counters with carry and overrides, illegal accesses and priority.
module tb_csr_unit;
  import csr_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        trap, mret, iret;
  logic [31:0] pc, cause, tval;
  logic [15:0] irq;
  logic [31:0] mepc, trap_pc, irq_cause;
  logic        irq_req;
  int          n_tests = 0;
  int          n_fail  = 0;

  csr_unit_if bus();

  csr_unit #(.NUM_IRQ(16), .VECTORED_EN(1'b1), .HART_ID(32'd0)) dut (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus),
    .trap_i(trap), .mret_i(mret), .pc_i(pc), .mcause_i(cause), .tval_i(tval),
    .instr_ret_i(iret), .irq_i(irq),
    .mepc_o(mepc), .trap_pc_o(trap_pc), .irq_req_o(irq_req), .irq_cause_o(irq_cause)
  );

  always #50 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
    bus.write_enable = 1'b0;
    bus.addr         = a;
    #1;
    chk(tag, bus.read_data, exp);
  endtask

  task automatic wr(input logic [2:0] op, input logic [11:0] a, input logic [31:0] v);
    bus.opcode = op; bus.addr = a; bus.rs1_data = v; bus.imm_data = v;
    bus.write_enable = 1'b1;
    tick;
    bus.write_enable = 1'b0;
  endtask

  initial begin
    bus.opcode = 3'b000; bus.addr = '0; bus.rs1_data = '0; bus.imm_data = '0;
    bus.write_enable = 1'b0;
    trap = 0; mret = 0; iret = 0; pc = '0; cause = '0; tval = '0; irq = '0;
    tick; tick;
    rst_n = 1'b1;

    rd("rst_mstatus", CSR_MSTATUS, 32'h0000_1800);
    rd("rst_mhartid", CSR_MHARTID, 32'h0);
    chk("rst_irq_req", {31'b0, irq_req}, 32'h0);
    chk("rst_trap_pc", trap_pc, 32'h0);

    // mie only keeps the platform-interrupt bits
    wr(CSR_OP_RW, CSR_MIE, 32'hFFFF_FFFF);
    rd("mie_mask", CSR_MIE, 32'hFFFF_0000);
    wr(CSR_OP_RC, CSR_MIE, 32'hFFFF_FFFF);
    rd("mie_clear", CSR_MIE, 32'h0);

    // interrupt request
    wr(CSR_OP_RS, CSR_MSTATUS, 32'h8);
    wr(CSR_OP_RS, CSR_MIE, 32'h0001_0000);
    irq = 16'h0001;
    #1 chk("irq_before_sync", {31'b0, irq_req}, 32'h0);
    tick;
    chk("irq_req", {31'b0, irq_req}, 32'h1);
    chk("irq_cause0", irq_cause, 32'h8000_0010);
    irq = 16'h0006;
    wr(CSR_OP_RS, CSR_MIE, 32'h0006_0000);
    rd("mip_read", CSR_MIP, 32'h0006_0000);
    chk("irq_cause_low", irq_cause, 32'h8000_0011);
    wr(CSR_OP_RC, CSR_MSTATUS, 32'h8);
    chk("irq_mie_off", {31'b0, irq_req}, 32'h0);
    wr(CSR_OP_RSI, CSR_MSTATUS, 32'h8);
    chk("irq_mie_on", {31'b0, irq_req}, 32'h1);

    // asynchronous reset mid-cycle
    wr(CSR_OP_RW, CSR_MSCRATCH, 32'hDEAD_BEEF);
    #20 rst_n = 1'b0;
    #1 chk("arst_irq_req", {31'b0, irq_req}, 32'h0);
    rd("arst_mie", CSR_MIE, 32'h0);
    rd("arst_mscratch", CSR_MSCRATCH, 32'h0);
    rd("arst_mstatus", CSR_MSTATUS, 32'h0000_1800);
    irq = '0;
    tick;
    rst_n = 1'b1;

    // trap entry, vectored target, mret
    wr(CSR_OP_RW, CSR_MTVEC, 32'h0000_2001);
    rd("mtvec", CSR_MTVEC, 32'h0000_2001);
    wr(CSR_OP_RS, CSR_MSTATUS, 32'h8);
    trap = 1; pc = 32'h100; tval = 32'hBAD; cause = 32'h2;
    #1 chk("trap_pc_exc", trap_pc, 32'h0000_2000);
    cause = 32'h8000_0011;
    #1 chk("trap_pc_vec", trap_pc, 32'h0000_2044);
    tick;
    trap = 0;
    rd("trap_mepc", CSR_MEPC, 32'h100);
    rd("trap_mcause", CSR_MCAUSE, 32'h8000_0011);
    rd("trap_mtval", CSR_MTVAL, 32'hBAD);
    rd("trap_mstatus", CSR_MSTATUS, 32'h0000_1880);
    chk("mepc_o", mepc, 32'h100);
    mret = 1;
    tick;
    mret = 0;
    rd("mret_mstatus", CSR_MSTATUS, 32'h0000_1888);
    wr(CSR_OP_RW, CSR_MEPC, 32'h103);
    rd("mepc_align", CSR_MEPC, 32'h100);

    // illegal accesses
    wr(CSR_OP_RW, CSR_MSCRATCH, 32'h1234);
    bus.opcode = CSR_OP_RW; bus.addr = 12'h7C0; bus.rs1_data = 32'hFFFF_FFFF;
    bus.write_enable = 1'b1;
    #1 chk("ill_unk_flag", {31'b0, bus.illegal}, 32'h1);
    chk("ill_unk_read", bus.read_data, 32'h0);
    tick;
    bus.addr = CSR_MIP;
    #1 chk("ill_mip_flag", {31'b0, bus.illegal}, 32'h1);
    chk("ill_mip_read", bus.read_data, 32'h0);
    tick;
    bus.write_enable = 1'b0;
    rd("ill_mscratch", CSR_MSCRATCH, 32'h1234);
    rd("ill_mip_kept", CSR_MIP, 32'h0);
    #1 chk("legal_flag", {31'b0, bus.illegal}, 32'h0);
    wr(3'b000, CSR_MSCRATCH, 32'h5555);
    rd("bad_op_nowrite", CSR_MSCRATCH, 32'h1234);
    wr(CSR_OP_RCI, CSR_MSCRATCH, 32'h4);
    rd("rci", CSR_MSCRATCH, 32'h1230);

    // mcycle carry and half-write override
    wr(CSR_OP_RW, CSR_MCYCLE, 32'hFFFF_FFFF);
    rd("mcyc_lo_wr", CSR_MCYCLE, 32'hFFFF_FFFF);
    rd("mcyc_hi_wr", CSR_MCYCLEH, 32'h0);
    tick;
    rd("mcyc_lo_wrap", CSR_MCYCLE, 32'h0);
    rd("mcyc_hi_carry", CSR_MCYCLEH, 32'h1);
    wr(CSR_OP_RW, CSR_MCYCLE, 32'hFFFF_FFFF);
    wr(CSR_OP_RW, CSR_MCYCLEH, 32'h0000_0ABC);
    rd("mcyc_hi_ovr", CSR_MCYCLEH, 32'h0000_0ABC);
    rd("mcyc_lo_hold", CSR_MCYCLE, 32'hFFFF_FFFF);
    tick;
    rd("mcyc_hi_next", CSR_MCYCLEH, 32'h0000_0ABD);

    // minstret
    wr(CSR_OP_RW, CSR_MINSTRET, 32'h5);
    iret = 1; tick; tick; tick;
    iret = 0; tick;
    rd("minstret_inc", CSR_MINSTRET, 32'h8);
    iret = 1;
    wr(CSR_OP_RW, CSR_MINSTRET, 32'h40);
    iret = 0;
    rd("minstret_ovr", CSR_MINSTRET, 32'h40);

    // trap beats mret beats CSR write
    trap = 1; mret = 1; pc = 32'h300;
    wr(CSR_OP_RW, CSR_MEPC, 32'h55);
    trap = 0; mret = 0;
    rd("prio_mepc", CSR_MEPC, 32'h300);
    rd("prio_mstatus", CSR_MSTATUS, 32'h0000_1880);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
